// File: rtl/fifo_ser_pkg.sv
// Shared types and default parameters for the FIFO drain serializer.
package fifo_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } drain_state_t;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_GAP_CYCLES = 1;
    localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/fifo_ser_shreg.sv
// Load/shift register: bit_o is always the next bit to be presented on the link.
module fifo_ser_shreg
    import fifo_ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            shreg <= '0;
        end else if (load_i) begin
            shreg <= data_i;
        end else if (shift_i) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign bit_o = shreg[0];

endmodule

// File: rtl/fifo_drain_serializer.sv
// Pops one FIFO head word at a time and streams it LSB-first over a valid/ready bit link.
module fifo_drain_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             pnding_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             pop_o,
    output logic             ser_o,
    output logic             ser_valid_o,
    input  logic             ser_ready_i,
    output logic             sof_o,
    output logic             eof_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] words_o
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    drain_state_t     state;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             load;
    logic             shift;
    logic             shreg_bit;

    assign accept = ser_valid_o & ser_ready_i;
    assign load   = (state == IDLE) & en_i & pnding_i;
    // The register shifts as each bit is copied into ser_o, so it is one bit ahead of the link.
    assign shift  = (state == LOAD) | ((state == SHIFT) & accept & (bit_cnt != LAST_BIT));
    assign busy_o = (state != IDLE);

    fifo_ser_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (data_i),
        .bit_o   (shreg_bit)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            pop_o       <= 1'b0;
            ser_o       <= 1'b0;
            ser_valid_o <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
            words_o     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        pop_o <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    pop_o       <= 1'b0;
                    ser_valid_o <= 1'b1;
                    ser_o       <= shreg_bit;
                    sof_o       <= 1'b1;
                    eof_o       <= 1'b0;
                    bit_cnt     <= '0;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (accept) begin
                        if (bit_cnt == LAST_BIT) begin
                            ser_valid_o <= 1'b0;
                            sof_o       <= 1'b0;
                            eof_o       <= 1'b0;
                            words_o     <= words_o + 1'b1;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            ser_o   <= shreg_bit;
                            sof_o   <= 1'b0;
                            eof_o   <= ((bit_cnt + 1'b1) == LAST_BIT);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == LAST_GAP) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
